// File: rtl/ext.sv
// ext: widens instr[15:0] to 32 bits (zero, sign, lui, branch offset) into a register cleared by async reset
module ext (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [1:0]  ImmSrc,
  output logic [31:0] imm
);
  logic [15:0] imm16;
  logic [31:0] nxt;
  logic        unused_hi;
  assign imm16     = instr[15:0];
  assign unused_hi = ^instr[31:16];
  always_comb
    nxt = ImmSrc == 2'b00 ? {16'h0000, imm16} :
          ImmSrc == 2'b01 ? {{16{imm16[15]}}, imm16} :
          ImmSrc == 2'b10 ? {imm16, 16'h0000} :
                            {{14{imm16[15]}}, imm16, 2'b00};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) imm <= '0;
    else        imm <= nxt;
endmodule

// File: tb/tb_ext.sv
// tb_ext: directed and random checks of the registered immediate extender
module tb_ext;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [1:0]  ImmSrc;
  logic [31:0] imm;
  int checks = 0;
  int errors = 0;

  ext dut (.clk(clk), .rst_n(rst_n), .instr(instr), .ImmSrc(ImmSrc), .imm(imm));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [31:0] w, input logic [1:0] s, input logic [31:0] exp, input string tag);
    instr  = w;
    ImmSrc = s;
    step();
    chk(tag, imm, exp);
  endtask

  function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] s);
    logic signed [15:0] h;
    logic signed [31:0] sx;
    h  = w[15:0];
    sx = h;
    case (s)
      2'd0:    return w & 32'h0000_FFFF;
      2'd1:    return sx;
      2'd2:    return w << 16;
      default: return sx * 4;
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    logic [1:0]  s;
    rst_n  = 1'b0;
    instr  = 32'hFFFF_FFFF;
    ImmSrc = 2'd1;
    #2;
    chk("reset_pre_edge", imm, 32'h0);
    step();
    chk("reset_edge1", imm, 32'h0);
    step();
    chk("reset_edge2", imm, 32'h0);
    rst_n = 1'b1;

    apply(32'h0000_F000, 2'd0, 32'h0000_F000, "sweep_zero");
    apply(32'h0000_F000, 2'd1, 32'hFFFF_F000, "sweep_sign");
    apply(32'h0000_F000, 2'd2, 32'hF000_0000, "sweep_lui");
    apply(32'h0000_F000, 2'd3, 32'hFFFF_C000, "sweep_branch");

    apply(32'hABCD_7FFF, 2'd0, 32'h0000_7FFF, "pos_zero");
    apply(32'hABCD_7FFF, 2'd1, 32'h0000_7FFF, "pos_sign");
    apply(32'hABCD_7FFF, 2'd2, 32'h7FFF_0000, "pos_lui");
    apply(32'hABCD_7FFF, 2'd3, 32'h0001_FFFC, "pos_branch");

    apply(32'h0000_8000, 2'd1, 32'hFFFF_8000, "min_sign");
    apply(32'h0000_8000, 2'd3, 32'hFFFE_0000, "min_branch");
    apply(32'hFFFF_0000, 2'd0, 32'h0, "zero_zero");
    apply(32'hFFFF_0000, 2'd1, 32'h0, "zero_sign");
    apply(32'hFFFF_0000, 2'd2, 32'h0, "zero_lui");
    apply(32'hFFFF_0000, 2'd3, 32'h0, "zero_branch");

    apply(32'h0000_1234, 2'd2, 32'h1234_0000, "lat_load");
    instr  = 32'h0000_8001;
    ImmSrc = 2'd1;
    #2;
    chk("lat_hold", imm, 32'h1234_0000);
    rst_n = 1'b0;
    #1;
    chk("async_clear", imm, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("async_stay_zero", imm, 32'h0);
    step();
    chk("async_restore", imm, 32'hFFFF_8001);

    for (int i = 0; i < 1000; i++) begin
      w = $urandom;
      s = 2'($urandom_range(0, 3));
      apply(w, s, ref_ext(w, s), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
